gf2n_power_sbox_seq: RTL and testbench

//  Sequential, parametrised S-box engine: y = x^E in GF(2^N) XOR replicated linear term parity(x & LIN_MASK).

---
 rtl/gf2n_sbox_pkg.sv | 23 ++
 rtl/gf2n_power_sbox_seq_if.sv | 36 +++
 rtl/gf2n_mul.sv | 33 +++
 rtl/gf2n_power_sbox_seq.sv | 129 ++++++++++++
 tb/tb_gf2n_power_sbox_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/gf2n_sbox_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : gf2n_sbox_pkg                                                     |
// | Brief  : Default field parameters and FSM state type for the S-box engine  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package gf2n_sbox_pkg;

    localparam int         N_DEF        = 6;
    localparam logic [6:0] POLY_DEF     = 7'b1000011;
    localparam int         EXP_W_DEF    = 6;
    localparam logic [5:0] LIN_MASK_DEF = 6'b010100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gf2n_power_sbox_seq_if.sv
// +----------------------------------------------------------------------------+
// | Module : gf2n_power_sbox_seq_if                                            |
// | Brief  : Request/response handshake bundle for the power S-box engine      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gf2n_power_sbox_seq_if
    import gf2n_sbox_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int EXP_W = EXP_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_x;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_y;
    logic             busy;

    modport master (
        output in_valid, in_x, in_exp, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_x, in_exp, out_ready,
        output in_ready, out_valid, out_y, busy
    );

endinterface

`default_nettype wire

// File: rtl/gf2n_mul.sv
// +----------------------------------------------------------------------------+
// | Module : gf2n_mul                                                          |
// | Brief  : Combinational GF(2^N) multiply, a*b reduced modulo POLY           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf2n_mul
    import gf2n_sbox_pkg::*;
#(
    parameter int         N    = N_DEF,
    parameter logic [N:0] POLY = POLY_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] p
);

    // MSB-first shift-and-add: each shift is reduced immediately, so the
    // 2N-1 bit carry-less product never materialises.
    always_comb begin
        p = '0;
        for (int i = N - 1; i >= 0; i--) begin
            p = {p[N-2:0], 1'b0} ^ (p[N-1] ? POLY[N-1:0] : '0);
            if (b[i]) begin
                p = p ^ a;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gf2n_power_sbox_seq.sv
// +----------------------------------------------------------------------------+
// | Module : gf2n_power_sbox_seq                                               |
// | Brief  : Constant-time y = x^E in GF(2^N) xor replicated parity(x & mask)  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf2n_power_sbox_seq
    import gf2n_sbox_pkg::*;
#(
    parameter int         N        = N_DEF,
    parameter logic [N:0] POLY     = POLY_DEF,
    parameter int         EXP_W    = EXP_W_DEF,
    parameter logic [N-1:0] LIN_MASK = LIN_MASK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gf2n_power_sbox_seq_if.slave  bus
);

    localparam int           CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [N-1:0]     x_q, x_d;
    logic [EXP_W-1:0] e_q, e_d;
    logic             t_q, t_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     sq;
    logic [N-1:0]     mul_op;
    logic [N-1:0]     step;

    // Square and conditional multiply chained in one cycle; multiplying by 1
    // on a zero bit keeps the datapath activity independent of E.
    assign mul_op = e_q[cnt_q] ? x_q : ONE;

    gf2n_mul #(.N(N), .POLY(POLY)) u_sq  (.a(acc_q), .b(acc_q),  .p(sq));
    gf2n_mul #(.N(N), .POLY(POLY)) u_mul (.a(sq),    .b(mul_op), .p(step));

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        e_d         = e_q;
        t_d         = t_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d        = bus.in_x;
                    e_d        = bus.in_exp;
                    t_d        = ^(bus.in_x & LIN_MASK);
                    acc_d      = ONE;
                    cnt_d      = CNT_W'(EXP_W - 1);
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                acc_d = step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    out_y_d     = step ^ {N{t_q}};
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            e_q         <= '0;
            t_q         <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            e_q         <= e_d;
            t_q         <= t_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_gf2n_power_sbox_seq.sv
// +----------------------------------------------------------------------------+
// | Module : tb_gf2n_power_sbox_seq                                            |
// | Brief  : Self-checking bench: vector table, corner sequences, full sweeps  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gf2n_power_sbox_seq;
    import gf2n_sbox_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gf2n_power_sbox_seq_if #(.N(6), .EXP_W(6)) bus6 ();
    gf2n_power_sbox_seq_if #(.N(4), .EXP_W(4)) bus4 ();

    gf2n_power_sbox_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    gf2n_power_sbox_seq #(
        .N        (4),
        .POLY     (5'b10011),
        .EXP_W    (4),
        .LIN_MASK (4'b0101)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    typedef struct {
        logic [5:0] x;
        logic [5:0] e;
        logic [5:0] y;
    } vec_t;

    vec_t tbl[9];
    int   exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: full carry-less product then reduction, power by repeated multiply.
    function automatic int gmul(input int n, input int poly, input int a, input int b);
        int p = 0;
        for (int i = 0; i < n; i++)
            if (((b >> i) & 1) != 0) p ^= (a << i);
        for (int i = 2 * n - 2; i >= n; i--)
            if (((p >> i) & 1) != 0) p ^= (poly << (i - n));
        return p;
    endfunction

    function automatic int model(input int n, input int poly, input int mask, input int x, input int e);
        int r = 1;
        for (int k = 0; k < e; k++) r = gmul(n, poly, r, x);
        if (($countones(x & mask) % 2) != 0) r ^= (1 << n) - 1;
        return r;
    endfunction

    task automatic run6(input int x, input int e, input int y_exp, input int hold);
        int         k;
        logic [5:0] y_cap;
        logic [5:0] xv;
        xv = x[5:0];
        k = 0;
        while (!bus6.in_ready && k < 20) begin @(posedge clk); #1; k++; end
        check("in_ready_wait", {31'd0, bus6.in_ready}, 32'd1);
        bus6.in_valid = 1'b1;
        bus6.in_x     = xv;
        bus6.in_exp   = e[5:0];
        @(posedge clk); #1;
        bus6.in_valid = 1'b0;
        exp_q.push_back(y_exp);
        k = 0;
        while (!bus6.out_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("latency", k, 32'd6);
        if (!bus6.out_valid) begin
            void'(exp_q.pop_front());
            return;
        end
        y_cap = bus6.out_y;
        check("busy_done", {31'd0, bus6.busy}, 32'd1);
        // Competing requests while the result is held must be refused.
        for (int c = 0; c < hold; c++) begin
            bus6.in_valid = 1'b1;
            bus6.in_x     = ~xv;
            bus6.in_exp   = e[5:0] ^ 6'h15;
            @(posedge clk); #1;
            check("hold_valid", {31'd0, bus6.out_valid}, 32'd1);
            check("hold_y", {26'd0, bus6.out_y}, {26'd0, y_cap});
            check("hold_in_ready", {31'd0, bus6.in_ready}, 32'd0);
        end
        bus6.in_valid  = 1'b0;
        bus6.out_ready = 1'b1;
        @(posedge clk); #1;
        bus6.out_ready = 1'b0;
        check("y", {26'd0, y_cap}, exp_q.pop_front());
        check("y_retained", {26'd0, bus6.out_y}, {26'd0, y_cap});
        check("post_valid", {31'd0, bus6.out_valid}, 32'd0);
        check("post_in_ready", {31'd0, bus6.in_ready}, 32'd1);
        check("post_busy", {31'd0, bus6.busy}, 32'd0);
    endtask

    task automatic run4(input int x, input int e);
        int k;
        k = 0;
        while (!bus4.in_ready && k < 20) begin @(posedge clk); #1; k++; end
        bus4.in_valid = 1'b1;
        bus4.in_x     = x[3:0];
        bus4.in_exp   = e[3:0];
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        exp_q.push_back(model(4, 'h13, 'h5, x, e));
        k = 0;
        while (!bus4.out_valid && k < 40) begin @(posedge clk); #1; k++; end
        check("n4_latency", k, 32'd4);
        check("n4_y", {28'd0, bus4.out_y}, exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    initial begin : main
        int seen;
        tbl[0] = '{6'h02, 6'd1,  6'h02};
        tbl[1] = '{6'h20, 6'd2,  6'h30};
        tbl[2] = '{6'h02, 6'd62, 6'h21};
        tbl[3] = '{6'h04, 6'd63, 6'h3E};
        tbl[4] = '{6'h00, 6'd0,  6'h01};
        tbl[5] = '{6'h00, 6'd52, 6'h00};
        tbl[6] = '{6'h14, 6'd1,  6'h14};
        tbl[7] = '{6'h10, 6'd1,  6'h2F};
        tbl[8] = '{6'h3F, 6'd0,  6'h01};

        bus6.in_valid = 1'b0; bus6.in_x = '0; bus6.in_exp = '0; bus6.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_x = '0; bus4.in_exp = '0; bus4.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, bus6.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus6.out_valid}, 32'd0);
        check("rst_out_y", {26'd0, bus6.out_y}, 32'd0);
        check("rst_busy", {31'd0, bus6.busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run6(tbl[i].x, tbl[i].e, tbl[i].y, 0);

        run6('h20, 2, 'h30, 10);

        // Abort mid-run: reset values immediately, and no stale result afterwards.
        bus6.in_valid = 1'b1; bus6.in_x = 6'h02; bus6.in_exp = 6'd1;
        @(posedge clk); #1;
        bus6.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy", {31'd0, bus6.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus6.out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, bus6.in_ready}, 32'd1);
        check("abort_busy", {31'd0, bus6.busy}, 32'd0);
        check("abort_out_y", {26'd0, bus6.out_y}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus6.out_valid) seen++;
        end
        check("no_ghost_result", seen, 32'd0);
        run6('h04, 63, 'h3E, 2);

        for (int x = 0; x < 64; x++)
            for (int e = 0; e < 64; e++)
                run6(x, e, model(6, 'h43, 'h14, x, e), 0);

        for (int x = 0; x < 16; x++)
            for (int e = 0; e < 16; e++)
                run4(x, e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
